dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder servicing the CPU datapath's load/store requests over a req/ack handshake. It latches one request, waits a programmable number of wait states, then commits a byte-masked write or returns read data with a one-cycle ack pulse. It flags misaligned and out-of-range addresses with an error response. It replaces the zero-latency data memory when the core is moved to a stalling memory interface.

## Interface
- `ADDR_W`, default 8: word-address bits. Depth is 2^ADDR_W 32-bit words.
- `WAIT`, default 2: wait states inserted before the access. Legal range 0..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `req`  in  1  request valid; the requester holds it high until it sees `ack`.
- `memWrt`  in  1  request type: 1 = write, 0 = read. Qualified by `req`.
- `addr`  in  32  byte address; the word index is `addr[ADDR_W+1:2]`.
- `Din`  in  32  write data.
- `be`  in  4  write byte enables; `be[i]` selects `Din[8i+7:8i]`.
- `ack`  out  1  one-cycle response pulse.
- `err`  out  1  error flag; valid only while `ack`=1.
- `Dout`  out  32  read data; updated only on a successful read ack, held otherwise.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, DONE.
  - **IDLE**
    - `req`=1: latch `addr`, `memWrt`, `Din`, `be`; load `cnt`=WAIT; go to WAIT.
    - `req`=0: stay in IDLE.
  - **WAIT**
    - `cnt`!=0: decrement `cnt`.
    - `cnt`==0: perform the access using the latched values; set `ack`=1; go to DONE.
  - **DONE**
    - `ack` returns to 0; go to IDLE unconditionally.
    - `req` is ignored in DONE. The requester drops `req` after the ack cycle; `req` still high in IDLE is a new request.
- Error check, on the latched address:
  - Error when `addr[1:0]`!=0, or when `addr[31:ADDR_W+2]`!=0.
  - On error: no write, `Dout` unchanged, `err`=1 with `ack`.
- Write: for each i with `be[i]`=1, `mem[word][8i+7:8i]` <= `Din[8i+7:8i]`. Other bytes are unchanged. `be`=0 is a legal no-op and acks normally. `Dout` is unchanged on a write.
- Read: `Dout` <= `mem[word]`, full word (`be` ignored), registered at the ack edge.
- `err` is 0 whenever `ack`=0.
- The memory array is not cleared by reset. Unwritten words read as undefined.

## Timing
- Reset values: state=IDLE, `cnt`=0, `ack`=0, `err`=0, `busy`=0, `Dout`=0.
- Request accepted at edge e0 (IDLE, `req`=1):
  - `busy` rises after e0.
  - Access commits and `ack` rises at edge e(WAIT+1).
  - `ack` falls at e(WAIT+2), when the FSM returns to IDLE and `busy` falls.
- Latency from accept edge to ack edge is WAIT+1 cycles. Minimum request-to-request spacing is WAIT+3 edges.
- `busy` is decoded from the state register (state!=IDLE) and stays high through the DONE cycle.
- Input changes after e0 have no effect on the in-flight request.
- Reset mid-operation (WAIT or DONE): the pending write is discarded and not committed. `ack` and `err` clear at that edge; `Dout` goes to 0.
- Simultaneous `reset`=0 and `req`=1: reset wins and the request is dropped.
- `WAIT`=0: the WAIT state lasts exactly one cycle; `ack` rises at e1.

## Test plan
- Reset, then write `addr`=0x10, `Din`=0xDEADBEEF, `be`=4'hF, `WAIT`=2 → `ack` rises exactly 3 edges after accept with `err`=0. A following read of 0x10 returns `Dout`=0xDEADBEEF and 1-cycle `ack`.
- Partial write: after the full write above, write 0x11223344 to 0x10 with `be`=4'b0101 → a read of 0x10 gives 0xDE22BE44. A write with `be`=0 leaves it unchanged and still acks.
- Errors: read `addr`=0x12 → `ack`=1, `err`=1, `Dout` keeps its prior value. Write `addr`=0x400 (ADDR_W=8) → `err`=1, no memory change; word 0 is unaffected on readback.
- Handshake: hold `req` high through the ack cycle and drop it the next cycle → exactly one access. Hold `req` high continuously → a new request is accepted every WAIT+3 edges and `busy` falls for exactly one cycle between accesses.
- Reset mid-write: drive `reset`=0 during WAIT of a write of 0xCAFEF00D to 0x20, after first writing 0x1 there → no `ack`, and `Dout`=0, `busy`=0 after the reset edge. A later read of 0x20 returns 0x1.
- `WAIT`=0 instance: back-to-back write then read of 0x3FC (word 255) → `ack` 1 edge after each accept, and the read returns the written data.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind a req/ack handshake.
// One request is latched in IDLE. After WAIT wait states the access happens
// using only the latched copy, and a one-cycle ack is returned with err.
// Ports:
//   clk, reset   - clock; synchronous active-low reset
//   req, memWrt  - request valid (held until ack); 1 = write, 0 = read
//   addr, Din, be - byte address, write data, write byte enables
//   ack, err     - one-cycle response pulse; error flag (only set with ack)
//   Dout         - read data, updated only on a successful read ack
//   busy         - high whenever the FSM is not in IDLE
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memWrt,
  input  logic [31:0] addr,
  input  logic [31:0] Din,
  input  logic [3:0]  be,
  output logic        ack,
  output logic        err,
  output logic [31:0] Dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  req_t              lat;
  logic              fire;
  logic              bad;
  logic [ADDR_W-1:0] word;

  logic [3:0][7:0] mem [2**ADDR_W];

  // Errors come from the latched address only: misaligned, or any bit set
  // above the word index.
  assign bad  = (|lat.addr[1:0]) | (|(lat.addr >> (ADDR_W + 2)));
  assign word = lat.addr[ADDR_W+1:2];
  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        state_nxt = S_WAIT;
        cnt_nxt   = 4'(WAIT);
      end
      S_WAIT: if (cnt != 4'd0) begin
        cnt_nxt = cnt - 4'd1;
      end else begin
        fire      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      Dout  <= 32'd0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= fire;
      err   <= fire & bad;
      if (state == S_IDLE && req)
        lat <= '{wr: memWrt, addr: addr, data: Din, be: be};
      if (fire && !lat.wr && !bad)
        Dout <= mem[word];
    end
  end

  // Storage is never cleared. Reset blocks a commit on the same edge so a
  // write interrupted by reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && fire && lat.wr && !bad) begin
      for (int b = 0; b < 4; b++)
        if (lat.be[b]) mem[word][b] <= lat.data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [2];
  logic        req_s  [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] din_s  [2];
  logic [3:0]  be_s   [2];
  logic        ack_s  [2];
  logic        err_s  [2];
  logic        busy_s [2];
  logic [31:0] dout_s [2];

  dmem_responder #(.ADDR_W(8), .WAIT(2)) u0 (
    .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .memWrt(wr_s[0]),
    .addr(addr_s[0]), .Din(din_s[0]), .be(be_s[0]),
    .ack(ack_s[0]), .err(err_s[0]), .Dout(dout_s[0]), .busy(busy_s[0]));

  dmem_responder #(.ADDR_W(8), .WAIT(0)) u1 (
    .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .memWrt(wr_s[1]),
    .addr(addr_s[1]), .Din(din_s[1]), .be(be_s[1]),
    .ack(ack_s[1]), .err(err_s[1]), .Dout(dout_s[1]), .busy(busy_s[1]));

  int wts [2] = '{2, 0};
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word arrays and last read value per instance.
  logic [31:0] mdl_mem  [2][256];
  logic [31:0] mdl_dout [2];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          x_err;
    logic [31:0] x_dout;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 10) != 32'd0);
  endfunction

  function automatic void mdl_apply(input int i, input bit wr, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] b);
    int w;
    if (is_bad(a)) return;
    w = int'(a[9:2]);
    if (wr) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) mdl_mem[i][w][8*k +: 8] = d[8*k +: 8];
    end else begin
      mdl_dout[i] = mdl_mem[i][w];
    end
  endfunction

  // One complete transaction: req held through the ack cycle and the DONE
  // edge, inputs scrambled after accept; checked against the model.
  task automatic transact(input int i, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic o_err, output logic [31:0] o_dout);
    int n;
    mdl_apply(i, wr, a, d, b);
    @(negedge clk);
    req_s[i] = 1'b1; wr_s[i] = wr; addr_s[i] = a; din_s[i] = d; be_s[i] = b;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy_s[i]), 32'd1);
    wr_s[i] = ~wr; addr_s[i] = $urandom; din_s[i] = $urandom; be_s[i] = 4'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ack_s[i]) break;
    end
    check("ack_latency", 32'(n), 32'(wts[i] + 1));
    check("err", 32'(err_s[i]), 32'(is_bad(a)));
    check("dout", dout_s[i], mdl_dout[i]);
    o_err  = err_s[i];
    o_dout = dout_s[i];
    @(posedge clk); #1;
    check("ack_fall", 32'(ack_s[i]), 32'd0);
    check("busy_fall", 32'(busy_s[i]), 32'd0);
    req_s[i] = 1'b0;
    @(posedge clk); #1;
    check("no_reaccept", 32'(busy_s[i]), 32'd0);
  endtask

  initial begin
    logic        oe;
    logic [31:0] od;
    logic [31:0] a;
    int          bad;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b0; req_s[i] = 1'b0; wr_s[i] = 1'b0;
      addr_s[i] = '0; din_s[i] = '0; be_s[i] = '0;
      mdl_dout[i] = '0;
    end

    tbl[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF,    1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,        4'h0,    1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h10,  32'h11223344, 4'b0101, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h10,  32'h0,        4'hF,    1'b0, 32'hDE22BE44};
    tbl[4] = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0,    1'b0, 32'hDE22BE44};
    tbl[5] = '{1'b0, 32'h10,  32'h0,        4'h0,    1'b0, 32'hDE22BE44};
    tbl[6] = '{1'b1, 32'h0,   32'h5555AAAA, 4'hF,    1'b0, 32'hDE22BE44};
    tbl[7] = '{1'b0, 32'h12,  32'h0,        4'hF,    1'b1, 32'hDE22BE44};
    tbl[8] = '{1'b1, 32'h400, 32'h12345678, 4'hF,    1'b1, 32'hDE22BE44};
    tbl[9] = '{1'b0, 32'h0,   32'h0,        4'hF,    1'b0, 32'h5555AAAA};

    // Reset state, with req asserted so reset must win.
    req_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ack",  32'(ack_s[i]),  32'd0);
      check("rst_err",  32'(err_s[i]),  32'd0);
      check("rst_busy", 32'(busy_s[i]), 32'd0);
      check("rst_dout", dout_s[i], 32'd0);
    end
    @(negedge clk);
    req_s[0] = 1'b0; rst_s[0] = 1'b1; rst_s[1] = 1'b1;

    // Directed vectors on the WAIT=2 instance.
    for (int v = 0; v < 10; v++) begin
      transact(0, tbl[v].wr, tbl[v].a, tbl[v].d, tbl[v].be, oe, od);
      check($sformatf("tbl%0d_err", v), 32'(oe), 32'(tbl[v].x_err));
      check($sformatf("tbl%0d_dout", v), od, tbl[v].x_dout);
    end

    // Continuous req: accept every WAIT+3 edges, busy low one cycle between.
    @(negedge clk);
    req_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = 32'h10; be_s[0] = 4'hF;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (ack_s[0]  !== ((k % 5) == 3)) bad++;
      if (busy_s[0] !== ((k % 5) != 4)) bad++;
    end
    req_s[0] = 1'b0;
    check("continuous_req_timing", 32'(bad), 32'd0);
    mdl_apply(0, 1'b0, 32'h10, 32'h0, 4'hF);
    check("continuous_req_dout", dout_s[0], 32'hDE22BE44);

    // Reset during WAIT of a write: nothing commits.
    transact(0, 1'b1, 32'h20, 32'h1, 4'hF, oe, od);
    @(negedge clk);
    req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 32'h20; din_s[0] = 32'hCAFEF00D; be_s[0] = 4'hF;
    @(posedge clk); #1;
    check("midrst_busy_pre", 32'(busy_s[0]), 32'd1);
    @(negedge clk);
    rst_s[0] = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack",  32'(ack_s[0]),  32'd0);
    check("midrst_busy", 32'(busy_s[0]), 32'd0);
    check("midrst_dout", dout_s[0], 32'd0);
    mdl_dout[0] = 32'd0;
    @(negedge clk);
    rst_s[0] = 1'b1; req_s[0] = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_s[0] !== 1'b0) bad++;
    end
    check("midrst_no_ack", 32'(bad), 32'd0);
    transact(0, 1'b0, 32'h20, 32'h0, 4'hF, oe, od);
    check("midrst_readback", od, 32'h1);

    // WAIT=0 instance: top word, write then read.
    transact(1, 1'b1, 32'h3FC, 32'hA5A50F0F, 4'hF, oe, od);
    transact(1, 1'b0, 32'h3FC, 32'h0, 4'hF, oe, od);
    check("w0_readback", od, 32'hA5A50F0F);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 8; w++)
        transact(i, 1'b1, 32'(w) << 2, $urandom, 4'hF, oe, od);
    for (int t = 0; t < 60; t++) begin
      int i;
      int r;
      i = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 7)) << 2;
      r = $urandom_range(0, 9);
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a | (32'd1 << $urandom_range(10, 31));
      transact(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), oe, od);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
